// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-addressed data memory
// Sub-word stores run as read-modify-write; rejected requests never touch memory.
module load_store_unit #(
    parameter int MEM_ADDR_W = 7
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic                  resp_error_o,
    output logic [31:0]           resp_rdata_o,
    output logic [MEM_ADDR_W-1:0] mem_address_o,
    output logic [31:0]           mem_write_data_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [31:0]           mem_data_out_i
);

    localparam int AW = MEM_ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     merge_q, merge_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            error_q, error_d;

    logic            req_err;
    logic [4:0]      shamt;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [31:0]     load_val;
    logic [31:0]     lane_mask;
    logic [31:0]     merge_val;

    assign req_err = (req_size_i == 2'b11)
                   | ((req_size_i == 2'b01) & req_addr_i[0])
                   | ((req_size_i == 2'b10) & (|req_addr_i[1:0]))
                   | (|(req_addr_i >> AW));

    // Half accesses are 2-byte aligned, so the byte shift also lands halfwords correctly.
    assign shamt     = {addr_q[1:0], 3'b000};
    assign lane_byte = 8'(mem_data_out_i >> shamt);
    assign lane_half = 16'(mem_data_out_i >> shamt);

    always_comb begin
        load_val = mem_data_out_i;
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_val = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_val = mem_data_out_i;
        endcase
    end

    assign lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    assign merge_val = (mem_data_out_i & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        unsigned_d       = unsigned_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        merge_d          = merge_q;
        rdata_d          = rdata_q;
        error_d          = error_q;
        req_ready_o      = 1'b0;
        resp_valid_o     = 1'b0;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_write_data_o = 32'h0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    addr_d     = req_addr_i[AW-1:0];
                    wdata_d    = req_wdata_i;
                    if (req_err) begin
                        error_d = 1'b1;
                        rdata_d = 32'h0;
                        state_d = S_RESP;
                    end else if (!req_write_i) begin
                        state_d = S_LOAD;
                    end else if (req_size_i == 2'b10) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_read_o = 1'b1;
                rdata_d    = load_val;
                error_d    = 1'b0;
                state_d    = S_RESP;
            end
            S_STORE: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = wdata_q;
                rdata_d          = 32'h0;
                error_d          = 1'b0;
                state_d          = S_RESP;
            end
            S_RMW_RD: begin
                mem_read_o = 1'b1;
                merge_d    = merge_val;
                state_d    = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = merge_q;
                rdata_d          = 32'h0;
                error_d          = 1'b0;
                state_d          = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    assign resp_rdata_o  = rdata_q;
    assign resp_error_o  = error_q;
    assign mem_address_o = addr_q[AW-1:2];

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural 128x32 memory
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_out;

    logic [31:0] mem [128];

    always #5 clock = ~clock;

    load_store_unit #(.MEM_ADDR_W(7)) dut (
        .clock_i          (clock),
        .reset_n_i        (reset_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_unsigned_i   (req_unsigned),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .resp_valid_o     (resp_valid),
        .resp_error_o     (resp_error),
        .resp_rdata_o     (resp_rdata),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_write_o      (mem_write),
        .mem_read_o       (mem_read),
        .mem_data_out_i   (mem_data_out)
    );

    assign mem_data_out = mem[mem_address];
    always @(posedge clock) if (mem_write) mem[mem_address] <= mem_write_data;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nrd = 0;
    int          nwr = 0;
    int          last_resp = 0;
    int          acc_cyc = 0;
    logic [31:0] last_wd = 32'h0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: bus activity and responses are compared against the queued expectations.
    always @(negedge clock) begin
        if (!reset_n) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (mem_read) nrd = nrd + 1;
            if (mem_write) begin
                nwr = nwr + 1;
                last_wd = mem_write_data;
            end else begin
                chk("wdata_idle_zero", mem_write_data, 32'h0);
            end
            if (sb.size() > 0) chk("ready_low_busy", {31'h0, req_ready}, 32'h0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_error", {31'h0, resp_error}, {31'h0, e.err});
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("mem_read_cycles", nrd, e.nrd);
                    chk("mem_write_cycles", nwr, e.nwr);
                    if (e.nwr > 0) chk("mem_write_data", last_wd, e.wd);
                end
                nrd = 0;
                nwr = 0;
                last_resp = cyc;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int erd, input int ewr, input logic [31:0] ewd,
                         input logic keep);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_write = wr;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        n = 0;
        @(negedge clock);
        #2;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            #2;
            n = n + 1;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
        end else begin
            e.err = err; e.rdata = rdata; e.acc = cyc; e.lat = lat;
            e.nrd = erd; e.nwr = ewr; e.wd = ewd;
            acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clock);
            n = n + 1;
        end
        if (sb.size() > 0) begin
            chk("resp_timeout", 32'h0, 32'h1);
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int first_resp;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[1]  = 32'h5566_7788;
        mem[3]  = 32'h9988_7766;
        mem[8]  = 32'h1122_3344;
        mem[13] = 32'h0000_000D;

        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", {25'h0, mem_address}, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        issue(0, 2'b10, 0, 32'h34, 32'h0, 0, 32'h0000_000D, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0, 32'h0, 2, 0, 1, 32'h80FF_7F01, 0);
        wait_done();
        chk("mem4_after_sw", mem[4], 32'h80FF_7F01);
        issue(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFF_FF80, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h0000_0080, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'hFFFF_80FF, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h0000_7F01, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(1, 2'b00, 0, 32'h11, 32'hAA, 0, 32'h0, 3, 1, 1, 32'h80FF_AA01, 0);
        wait_done();
        chk("mem4_after_sb", mem[4], 32'h80FF_AA01);
        issue(1, 2'b01, 0, 32'h0E, 32'h1234_CAFE, 0, 32'h0, 3, 1, 1, 32'hCAFE_7766, 0);
        wait_done();
        chk("mem3_after_sh", mem[3], 32'hCAFE_7766);

        issue(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFF_FF80, 2, 1, 0, 32'h0, 0);
        wait_done();
        issue(0, 2'b01, 0, 32'h05, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, 0);
        wait_done();
        issue(1, 2'b10, 0, 32'h06, 32'hDEAD_BEEF, 1, 32'h0, 1, 0, 0, 32'h0, 0);
        wait_done();
        chk("mem1_unchanged", mem[1], 32'h5566_7788);
        issue(0, 2'b11, 0, 32'h08, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, 0);
        wait_done();
        issue(0, 2'b10, 0, 32'h200, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, 0);
        wait_done();

        issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80FF_AA01, 2, 1, 0, 32'h0, 1);
        first_resp = acc_cyc + 2;
        issue(0, 2'b00, 1, 32'h12, 32'h0, 0, 32'h0000_00FF, 2, 1, 0, 32'h0, 0);
        chk("b2b_accept_cycle", acc_cyc, first_resp + 1);
        wait_done();

        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b01;
        req_unsigned = 1'b0;
        req_addr = 32'h20;
        req_wdata = 32'h0000_BEEF;
        @(negedge clock);
        #2;
        chk("rmw_accept_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("rmw_wr_active", {31'h0, mem_write}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("arst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("arst_wdata", mem_write_data, 32'h0);
        chk("arst_ready", {31'h0, req_ready}, 32'h1);
        chk("arst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
        chk("arst_rdata", resp_rdata, 32'h0);
        chk("arst_addr", {25'h0, mem_address}, 32'h0);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("mem8_unchanged", mem[8], 32'h1122_3344);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst_outputs", {29'h0, resp_valid, mem_read, mem_write}, 32'h0);
        issue(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h1122_3344, 2, 1, 0, 32'h0, 0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory (128 x 32-bit, combinational read, write on posedge clock).
- Converts byte-addressed core requests (byte, halfword, word; signed or unsigned loads) into word accesses.
- Sub-word stores are done as read-modify-write sequences.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
- MEM_ADDR_W, 7, word-index width driven to memory; byte address range is 0 .. 2^(MEM_ADDR_W+2)-1.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  valid with resp_valid; request rejected.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- mem_address  out  MEM_ADDR_W  word index = latched addr[MEM_ADDR_W+1:2].
- mem_write_data  out  32  data to memory; 0 when mem_write=0.
- mem_write  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_data_out  in  32  combinational memory read data.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0; mem_read=0; mem_write=0; mem_write_data=0; mem_address=0; all latches cleared.
- mem_read, mem_write and mem_write_data are decoded from state only. An async reset therefore drops them immediately, and an interrupted read-modify-write never issues its write.
- Data format is little-endian: byte lane = addr[1:0] (lane 0 = bits [7:0]); half lane = addr[1].
- IDLE: req_ready=1. When req_valid=1 at a posedge, latch write/size/unsigned/addr/wdata and go to:
  - RESP with error if size=11, or size=01 and addr[0]=1, or size=10 and addr[1:0]!=0, or addr[31:MEM_ADDR_W+2]!=0;
  - LOAD if load;
  - STORE if word store;
  - RMW_RD if byte/half store.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored.
- LOAD: mem_read=1. At the posedge, select lane from mem_data_out, sign- or zero-extend, register into resp_rdata, go to RESP.
- STORE: mem_write=1, mem_write_data=wdata; memory writes at this posedge; go to RESP.
- RMW_RD: mem_read=1. At the posedge, register merge word = mem_data_out with the target lane replaced by wdata[7:0] or [15:0]; go to RMW_WR.
- RMW_WR: mem_write=1, mem_write_data=merge word; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_error and resp_rdata held; next state IDLE.
  - resp_rdata=0 for stores and errors.
  - resp_rdata/resp_error hold their value until the next response is loaded.
- Latency, counted from the accepting edge to the cycle resp_valid is high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back: the next request is accepted on the edge leaving RESP→IDLE at the earliest, i.e. one idle cycle between requests.
- Error requests produce no mem_read or mem_write activity.

Test Plan:
- Memory preloaded with word 13 = 0x0000000D. Load word at addr 0x34 -> resp_valid 2 cycles after accept, resp_rdata=0x0000000D, resp_error=0, mem_write never asserted.
- Word store 0x80FF7F01 to addr 0x10, then loads from addr 0x13:
  - LB -> 0xFFFFFF80;
  - LBU -> 0x00000080;
  - LH at 0x12 -> 0xFFFF80FF;
  - LHU at 0x10 -> 0x00007F01.
- SB 0xAA to addr 0x11 over word 0x80FF7F01 -> memory word 4 = 0x80FFAA01. Check one mem_read cycle, then one mem_write cycle with mem_write_data=0x80FFAA01, then resp_valid 3 cycles after accept.
- Misaligned and illegal requests: LH addr 0x05, SW addr 0x06, size=11, addr 0x200 -> each gives resp_valid with resp_error=1 and resp_rdata=0 one cycle after accept; mem_read/mem_write stay 0 and memory is unchanged.
- Reset mid-operation: pull reset_n low during RMW_WR of SH 0xBEEF to addr 0x20 -> mem_write drops immediately, memory word 8 is unchanged, and after release req_ready=1 with all outputs at reset values.
- Back-to-back requests with req_valid held high -> second request accepted only after resp_valid; req_ready=0 in all non-IDLE states.
